sine_voice_sched: RTL and testbench

SINE_VOICE_SCHED -- requirements
Module: sine_voice_sched

---
 rtl/sine_voice_sched_if.sv | 31 +++
 rtl/sine_voice_sched.sv | 175 +++++++++++++++++
 tb/tb_sine_voice_sched.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_voice_sched_if.sv
// Host, lookup and mix signals of the sine voice scheduler, bundled as one interface.
// master = the driving environment (host plus sine lookup); slave = the scheduler.
interface sine_voice_sched_if #(
    parameter int NUM_VOICES = 4
);
    logic                  i_sample_tick;
    logic [NUM_VOICES-1:0] i_gate;
    logic                  i_freq_wr;
    logic [2:0]            i_voice_sel;
    logic [15:0]           i_freq_data;
    logic                  i_amp_wr;
    logic [7:0]            i_amp_data;
    logic [15:0]           o_lut_addr;
    logic [15:0]           i_lut_data;
    logic signed [18:0]    o_mix;
    logic                  o_mix_valid;
    logic                  o_busy;
    logic                  o_overrun;

    modport master (
        output i_sample_tick, i_gate, i_freq_wr, i_voice_sel, i_freq_data,
               i_amp_wr, i_amp_data, i_lut_data,
        input  o_lut_addr, o_mix, o_mix_valid, o_busy, o_overrun
    );

    modport slave (
        input  i_sample_tick, i_gate, i_freq_wr, i_voice_sel, i_freq_data,
               i_amp_wr, i_amp_data, i_lut_data,
        output o_lut_addr, o_mix, o_mix_valid, o_busy, o_overrun
    );
endinterface

// File: rtl/sine_voice_sched.sv
// Time-shares one sine lookup across NUM_VOICES phase accumulators and sums the
// returned samples into one signed 19-bit mix per sample tick.
// Optional feature: define SINE_SCHED_AMP_EN to add a per-voice 8-bit amplitude
// (sample * amp >>> 8); without it the amplitude inputs are ignored.
module sine_voice_sched #(
    parameter int NUM_VOICES  = 4,
    parameter int LUT_LATENCY = 3
) (
    input logic               i_clk,
    input logic               i_rst_n,
    sine_voice_sched_if.slave bus
);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // One in-flight lookup: which voice it belongs to and whether it counts.
    typedef struct packed {
        logic          valid;
        logic          gate;
        logic [IW-1:0] voice;
    } slot_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [15:0]           freq    [NUM_VOICES];
    logic [15:0]           freq_sh [NUM_VOICES];
    logic [15:0]           phase   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_sh;
    slot_t                 pipe    [LUT_LATENCY];
    slot_t                 tail;
    logic signed [18:0]    acc;
    logic signed [18:0]    acc_next;
    logic signed [18:0]    mix;
    logic [15:0]           contrib;
    logic [15:0]           lut_addr;
    logic                  mix_valid;
    logic                  busy;
    logic                  overrun;

    assign tail            = pipe[LUT_LATENCY-1];
    assign bus.o_lut_addr  = lut_addr;
    assign bus.o_mix       = mix;
    assign bus.o_mix_valid = mix_valid;
    assign bus.o_busy      = busy;
    assign bus.o_overrun   = overrun;

`ifdef SINE_SCHED_AMP_EN
    logic [7:0]         amp    [NUM_VOICES];
    logic [7:0]         amp_sh [NUM_VOICES];
    logic signed [24:0] prod;
    logic               unused_prod;

    // Signed sample times unsigned amplitude; bits [23:8] are the >>>8 result.
    assign prod = $signed({{9{bus.i_lut_data[15]}}, bus.i_lut_data})
                * $signed({17'd0, amp_sh[tail.voice]});
    assign unused_prod = ^{prod[24], prod[7:0]};
`else
    logic unused_amp;
    assign unused_amp = ^{bus.i_amp_wr, bus.i_amp_data};
`endif

    // Live per-voice registers written by the host strobes; out-of-range selects match nothing.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: these small register arrays are reset on purpose -- the phase/frequency
            // state must be deterministic after reset, so they are not left as plain RAM.
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq[v] <= '0;
`ifdef SINE_SCHED_AMP_EN
                amp[v]  <= 8'hFF;
`endif
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (bus.i_freq_wr && (32'(bus.i_voice_sel) == v))
                    freq[v] <= bus.i_freq_data;
`ifdef SINE_SCHED_AMP_EN
                if (bus.i_amp_wr && (32'(bus.i_voice_sel) == v))
                    amp[v] <= bus.i_amp_data;
`endif
            end
        end
    end

    // Contribution of the sample returning this cycle: zero unless a gated-on slot is due.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        contrib = '0;
        if (tail.valid && tail.gate) begin
`ifdef SINE_SCHED_AMP_EN
            contrib = prod[23:8];
`else
            contrib = bus.i_lut_data;
`endif
        end
        acc_next = acc + {{3{contrib[15]}}, contrib};
    end

    // Frame sequencer: accept a tick, issue one lookup per voice, accumulate returns, publish.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            gate_sh   <= '0;
            acc       <= '0;
            mix       <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            lut_addr  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v]   <= '0;
                freq_sh[v] <= '0;
`ifdef SINE_SCHED_AMP_EN
                amp_sh[v]  <= 8'hFF;
`endif
            end
            for (int i = 0; i < LUT_LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments below override these defaults.
            mix_valid <= 1'b0;
            for (int i = LUT_LATENCY - 1; i > 0; i--)
                pipe[i] <= pipe[i-1];
            pipe[0] <= '0;

            if (tail.valid)
                acc <= acc_next;
            if (bus.i_sample_tick && busy)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.i_sample_tick) begin
                        state    <= ISSUE;
                        idx      <= '0;
                        busy     <= 1'b1;
                        acc      <= '0;
                        lut_addr <= phase[0];
                        gate_sh  <= bus.i_gate;
                        freq_sh  <= freq;
`ifdef SINE_SCHED_AMP_EN
                        amp_sh   <= amp;
`endif
                    end
                end
                ISSUE: begin
                    pipe[0] <= {1'b1, gate_sh[idx], idx};
                    if (gate_sh[idx])
                        phase[idx] <= phase[idx] + freq_sh[idx];
                    if (idx == LAST) begin
                        state <= DRAIN;
                    end else begin
                        idx      <= idx + IW'(1);
                        lut_addr <= phase[idx + IW'(1)];
                    end
                end
                DRAIN: begin
                    if (tail.valid && (tail.voice == LAST)) begin
                        mix       <= acc_next;
                        mix_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sine_voice_sched.sv
// Scoreboard bench for sine_voice_sched: frames are predicted from phase/frequency
// arithmetic when a tick is issued; a negedge monitor checks every o_mix_valid.
module tb_sine_voice_sched;
    localparam int NV        = 4;
    localparam int LAT       = 3;
    localparam int FRAME_LAT = NV + LAT + 1;

    typedef struct {
        logic signed [18:0] mix;
        int                 cyc;
    } exp_t;

    logic  clk      = 1'b0;
    logic  rst_n    = 1'b0;
    int    cyc      = 0;
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    mv_count = 0;
    int    lut_mode = 0;
    exp_t  sbq[$];

    logic [15:0] m_phase  [NV];
    logic [15:0] m_freq   [NV];
    logic [7:0]  m_amp    [NV];
    logic [15:0] exp_addr [NV];
    logic [15:0] dpipe    [LAT];

    sine_voice_sched_if #(.NUM_VOICES(NV)) bus();

    sine_voice_sched #(.NUM_VOICES(NV), .LUT_LATENCY(LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub sine table: a few constant modes for boundary sums, plus a scrambled mode.
    function automatic logic [15:0] lut_f(input logic [15:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'd40503;
        case (lut_mode)
            0:       return 16'h7FFF;
            1:       return 16'h4000;
            2:       return 16'h8000;
            default: return h[23:8] ^ 16'h3C5A;
        endcase
    endfunction

    // Lookup with a fixed LAT-cycle latency from address to data.
    always @(posedge clk) begin
        dpipe[0] <= lut_f(bus.o_lut_addr);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bus.i_lut_data = dpipe[LAT-1];

    function automatic int scale(input logic [15:0] s, input logic [7:0] a);
        int p;
`ifdef SINE_SCHED_AMP_EN
        p = int'($signed(s)) * int'(a);
        return p >>> 8;
`else
        p = int'($signed(s));
        return p;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = '0;
            m_freq[v]  = '0;
            m_amp[v]   = 8'hFF;
        end
    endtask

    task automatic model_freq_wr(input logic [2:0] sel, input logic [15:0] data);
        if (int'(sel) < NV) m_freq[sel] = data;
    endtask

    // Called in the tick cycle: predicts addresses, the mix and its arrival cycle.
    task automatic model_accept(input logic [NV-1:0] g);
        int   sum;
        exp_t e;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            exp_addr[v] = m_phase[v];
            if (g[v]) begin
                sum += scale(lut_f(m_phase[v]), m_amp[v]);
                m_phase[v] = m_phase[v] + m_freq[v];
            end
        end
        e.mix = sum[18:0];
        e.cyc = cyc + FRAME_LAT;
        sbq.push_back(e);
    endtask

    task automatic wr_freq(input logic [2:0] sel, input logic [15:0] data);
        @(negedge clk);
        bus.i_freq_wr = 1'b1; bus.i_voice_sel = sel; bus.i_freq_data = data;
        model_freq_wr(sel, data);
        @(negedge clk);
        bus.i_freq_wr = 1'b0;
    endtask

    task automatic wr_amp(input logic [2:0] sel, input logic [7:0] data);
        @(negedge clk);
        bus.i_amp_wr = 1'b1; bus.i_voice_sel = sel; bus.i_amp_data = data;
        if (int'(sel) < NV) m_amp[sel] = data;
        @(negedge clk);
        bus.i_amp_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.o_busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'(bus.o_busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_sample_tick = 1'b0; bus.i_freq_wr = 1'b0; bus.i_amp_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One accepted frame, optionally with a frequency write in the tick cycle.
    task automatic run_frame(input logic [NV-1:0] g, input bit wr,
                             input logic [2:0] sel, input logic [15:0] data);
        @(negedge clk);
        bus.i_sample_tick = 1'b1; bus.i_gate = g;
        bus.i_freq_wr = wr; bus.i_voice_sel = sel; bus.i_freq_data = data;
        model_accept(g);
        if (wr) model_freq_wr(sel, data);
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            bus.i_sample_tick = 1'b0; bus.i_freq_wr = 1'b0; bus.i_gate = ~g;
            if (v == 0) check("busy_in_frame", 32'(bus.o_busy), 1);
            check("lut_addr", 32'(bus.o_lut_addr), 32'(exp_addr[v]));
        end
        wait_idle();
        check("addr_hold", 32'(bus.o_lut_addr), 32'(exp_addr[NV-1]));
    endtask

    // Monitor: every o_mix_valid must match the oldest prediction, value and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.o_mix_valid === 1'b1) begin
            mv_count++;
            if (sbq.size() == 0) begin
                check("unexpected_mix_valid", 32'(bus.o_mix_valid), 0);
            end else begin
                e = sbq.pop_front();
                check("mix", 32'(bus.o_mix), 32'(e.mix));
                check("mix_cycle", cyc, e.cyc);
                check("busy_at_valid", 32'(bus.o_busy), 1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        bus.i_sample_tick = 1'b0; bus.i_gate = '0; bus.i_freq_wr = 1'b0;
        bus.i_voice_sel = '0; bus.i_freq_data = '0; bus.i_amp_wr = 1'b0; bus.i_amp_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_lut_addr", 32'(bus.o_lut_addr), 0);
        check("rst_mix", 32'(bus.o_mix), 0);
        check("rst_mix_valid", 32'(bus.o_mix_valid), 0);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_overrun", 32'(bus.o_overrun), 0);

        // Single voice at phase 0, then the incremented phase on the next frame.
        lut_mode = 3;
        wr_freq(3'd0, 16'h1000);
        run_frame(4'b0001, 1'b0, 3'd0, 16'h0);
        run_frame(4'b0001, 1'b0, 3'd0, 16'h0);

        // Full-scale sums, positive and negative.
        lut_mode = 0;
        run_frame(4'b1111, 1'b0, 3'd0, 16'h0);
        lut_mode = 2;
        run_frame(4'b1111, 1'b0, 3'd0, 16'h0);

        // Phase wrap on voice 1 and a write landing in the tick cycle.
        lut_mode = 3;
        wr_freq(3'd1, 16'h0001);
        run_frame(4'b0010, 1'b0, 3'd0, 16'h0);
        wr_freq(3'd1, 16'hFFFF);
        run_frame(4'b0010, 1'b0, 3'd0, 16'h0);
        run_frame(4'b0010, 1'b1, 3'd1, 16'h0005);
        run_frame(4'b0010, 1'b0, 3'd0, 16'h0);
        run_frame(4'b0010, 1'b0, 3'd0, 16'h0);

        // Amplitude half-scale on voice 0 (ignored without the amplitude option).
        lut_mode = 1;
        wr_amp(3'd0, 8'h80);
        run_frame(4'b0001, 1'b0, 3'd0, 16'h0);

        // Randomized writes, gates and tick-cycle writes.
        lut_mode = 3;
        for (int it = 0; it < 16; it++) begin
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) wr_freq(3'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 1) == 1) wr_amp(3'($urandom_range(0, 7)), 8'($urandom));
            run_frame(NV'($urandom), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 16'($urandom));
        end

        // Tick while busy is dropped and sets a sticky overrun.
        do_reset();
        wr_freq(3'd2, 16'h0123);
        @(negedge clk);
        bus.i_sample_tick = 1'b1; bus.i_gate = 4'b0101;
        model_accept(4'b0101);
        base = mv_count;
        @(negedge clk);
        bus.i_sample_tick = 1'b0;
        check("overrun_before", 32'(bus.o_overrun), 0);
        @(negedge clk);
        @(negedge clk);
        bus.i_sample_tick = 1'b1;
        @(negedge clk);
        bus.i_sample_tick = 1'b0;
        check("overrun_set", 32'(bus.o_overrun), 1);
        wait_idle();
        repeat (12) @(negedge clk);
        check("one_mix_valid", mv_count - base, 1);
        check("overrun_sticky", 32'(bus.o_overrun), 1);

        // Tick in the DONE cycle is dropped.
        do_reset();
        @(negedge clk);
        bus.i_sample_tick = 1'b1; bus.i_gate = 4'b1111;
        model_accept(4'b1111);
        @(negedge clk);
        bus.i_sample_tick = 1'b0;
        n = 0;
        while (bus.o_mix_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(bus.o_mix_valid), 1);
        bus.i_sample_tick = 1'b1;
        @(negedge clk);
        bus.i_sample_tick = 1'b0;
        check("done_tick_not_accepted", 32'(bus.o_busy), 0);
        check("done_tick_overrun", 32'(bus.o_overrun), 1);

        // Reset mid-frame aborts it: no mix, all outputs zero.
        do_reset();
        wr_freq(3'd0, 16'h0040);
        base = mv_count;
        @(negedge clk);
        bus.i_sample_tick = 1'b1; bus.i_gate = 4'b1111;
        @(negedge clk);
        bus.i_sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_lut_addr", 32'(bus.o_lut_addr), 0);
        check("abort_mix", 32'(bus.o_mix), 0);
        check("abort_mix_valid", 32'(bus.o_mix_valid), 0);
        check("abort_busy", 32'(bus.o_busy), 0);
        check("abort_overrun", 32'(bus.o_overrun), 0);
        rst_n = 1'b1;
        model_reset();
        repeat (12) @(negedge clk);
        check("abort_no_mix_valid", mv_count - base, 0);

        // A clean frame after the abort still works.
        lut_mode = 3;
        run_frame(4'b1011, 1'b0, 3'd0, 16'h0);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
